// File: rtl/pacman_sprite_engine.sv
// pacman_sprite_engine: procedural Pac-Man renderer (disc plus wedge mouth) with chomp/death animation.
// Rev 1.0 - initial release.
`default_nettype none

module pacman_sprite_engine #(
  parameter int          R           = 7,
  parameter int          COORD_W     = 10,
  parameter int          FRAME_DIV   = 4,
  parameter int          DEATH_STEPS = 8,
  parameter logic [7:0]  FG          = 8'hFC,
  parameter logic [7:0]  BG          = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  input  logic [COORD_W-1:0] xloc,
  input  logic [COORD_W-1:0] yloc,
  input  logic [1:0]         dir,
  input  logic               moving,
  input  logic               kill,
  input  logic               revive,
  output logic [7:0]         color,
  output logic               alive,
  output logic               death_done
);

  localparam int DW    = COORD_W + 1;
  localparam int SW    = $clog2(R + 1) + 1;
  localparam int MW    = $clog2(4 * DEATH_STEPS + 5);
  localparam int PW    = MW + SW;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int K_W   = (DEATH_STEPS > 1) ? $clog2(DEATH_STEPS) : 1;

  localparam logic signed [DW-1:0] R_HI     = DW'(R);
  localparam logic signed [DW-1:0] R_LO     = -R_HI;
  localparam logic [2*SW:0]        BODY_LIM = (2*SW+1)'(R * R + R);

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_DYING = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         phase;
  logic [DIV_W-1:0]   div;
  logic [K_W-1:0]     k;
  logic [COORD_W-1:0] lx, ly;
  logic [1:0]         ldir;

  logic               div_wrap, k_last;

  assign div_wrap = (div == DIV_W'(FRAME_DIV - 1));
  assign k_last   = (k == K_W'(DEATH_STEPS - 1));
  assign alive    = (state == ST_ALIVE);

  // Animation state; a kill/revive edge clears the divider so a coincident tick is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ALIVE;
      phase      <= 2'd0;
      div        <= '0;
      k          <= '0;
      death_done <= 1'b0;
    end else begin
      death_done <= 1'b0;
      case (state)
        ST_ALIVE: begin
          if (kill) begin
            state <= ST_DYING;
            k     <= '0;
            div   <= '0;
          end else if (frame_tick && moving) begin
            if (div_wrap) begin
              div   <= '0;
              phase <= phase + 2'd1;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (div_wrap) begin
              div <= '0;
              if (k_last) begin
                state      <= ST_DEAD;
                death_done <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (revive) begin
            state <= ST_ALIVE;
            phase <= 2'd0;
            div   <= '0;
          end
        end
        default: state <= ST_ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx   <= '0;
      ly   <= '0;
      ldir <= 2'd0;
    end else if (frame_tick) begin
      lx   <= xloc;
      ly   <= yloc;
      ldir <= dir;
    end
  end

  // Stage 1: offsets, bounding box, direction rotation and mouth level.
  logic signed [DW-1:0] dx_full, dy_full;
  logic [SW-1:0]        dx_s, dy_s, a_c, p_c;
  logic                 inbox_c;
  logic [MW-1:0]        m_c;

  assign dx_full = $signed({1'b0, xpos}) - $signed({1'b0, lx});
  assign dy_full = $signed({1'b0, ypos}) - $signed({1'b0, ly});
  assign inbox_c = (dx_full >= R_LO) && (dx_full <= R_HI) &&
                   (dy_full >= R_LO) && (dy_full <= R_HI);
  assign dx_s    = dx_full[SW-1:0];
  assign dy_s    = dy_full[SW-1:0];

  always_comb begin
    a_c = dx_s;
    p_c = dy_s;
    case (ldir)
      2'b00: begin a_c = dx_s;            p_c = dy_s; end
      2'b11: begin a_c = ~dx_s + 1'b1;    p_c = dy_s; end
      2'b01: begin a_c = ~dy_s + 1'b1;    p_c = dx_s; end
      default: begin a_c = dy_s;          p_c = dx_s; end
    endcase
  end

  always_comb begin
    m_c = '0;
    case (state)
      ST_ALIVE: begin
        case (phase)
          2'd0:    m_c = MW'(4);
          2'd1:    m_c = MW'(2);
          2'd2:    m_c = '0;
          default: m_c = MW'(2);
        endcase
      end
      ST_DYING: m_c = MW'({k, 2'b00}) + MW'(4);
      default:  m_c = '0;
    endcase
  end

  logic          s1_inbox;
  logic [SW-1:0] s1_dx, s1_dy, s1_a, s1_p;
  logic [MW-1:0] s1_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inbox <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_a     <= '0;
      s1_p     <= '0;
      s1_m     <= '0;
    end else begin
      s1_inbox <= inbox_c;
      s1_dx    <= dx_s;
      s1_dy    <= dy_s;
      s1_a     <= a_c;
      s1_p     <= p_c;
      s1_m     <= m_c;
    end
  end

  // Stage 2: disc test and mouth wedge; products are exact since |dx|,|dy|,|a|,|p| <= R here.
  logic [2*SW-1:0] dx_e, dy_e, dx2, dy2;
  logic [2*SW:0]   body_sum;
  logic [SW-1:0]   p_abs;
  logic [PW-1:0]   m_a, p4;
  logic            body, mouth;

  assign dx_e     = {{SW{s1_dx[SW-1]}}, s1_dx};
  assign dy_e     = {{SW{s1_dy[SW-1]}}, s1_dy};
  assign dx2      = dx_e * dx_e;
  assign dy2      = dy_e * dy_e;
  assign body_sum = {1'b0, dx2} + {1'b0, dy2};
  assign body     = (body_sum <= BODY_LIM);
  assign p_abs    = s1_p[SW-1] ? (~s1_p + 1'b1) : s1_p;
  assign m_a      = {{SW{1'b0}}, s1_m} * {{MW{1'b0}}, s1_a};
  assign p4       = {{(PW-SW-2){1'b0}}, p_abs, 2'b00};
  assign mouth    = (s1_m != '0) && !s1_a[SW-1] && (p4 <= m_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color <= BG;
    end else begin
      color <= (s1_inbox && body && !mouth && (state != ST_DEAD)) ? FG : BG;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pacman_sprite_engine.sv
// tb_pacman_sprite_engine: directed and randomized checks against a frame-count based reference model.
`default_nettype none

module tb_pacman_sprite_engine;

  localparam int         R           = 7;
  localparam int         COORD_W     = 10;
  localparam int         FRAME_DIV   = 4;
  localparam int         DEATH_STEPS = 8;
  localparam logic [7:0] FG          = 8'hFC;
  localparam logic [7:0] BG          = 8'h00;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic [COORD_W-1:0] xpos = '0, ypos = '0, xloc = '0, yloc = '0;
  logic [1:0]         dir = 2'd0;
  logic               moving = 1'b0, kill = 1'b0, revive = 1'b0;
  logic [7:0]         color;
  logic               alive, death_done;

  always #5 clk = ~clk;

  pacman_sprite_engine #(
    .R(R), .COORD_W(COORD_W), .FRAME_DIV(FRAME_DIV),
    .DEATH_STEPS(DEATH_STEPS), .FG(FG), .BG(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .xpos(xpos), .ypos(ypos), .xloc(xloc), .yloc(yloc),
    .dir(dir), .moving(moving), .kill(kill), .revive(revive),
    .color(color), .alive(alive), .death_done(death_done)
  );

  int checks = 0;
  int failures = 0;
  int dd_count = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel rule straight from the geometry: box, disc, wedge.
  function automatic bit fg_pixel(int x, int y, int lx, int ly, int d, int m);
    int dx, dy, a, p;
    dx = x - lx;
    dy = y - ly;
    if (dx < -R || dx > R || dy < -R || dy > R) return 1'b0;
    if (dx * dx + dy * dy > R * R + R) return 1'b0;
    case (d)
      0:       begin a = dx;  p = dy; end
      3:       begin a = -dx; p = dy; end
      1:       begin a = -dy; p = dx; end
      default: begin a = dy;  p = dx; end
    endcase
    if (p < 0) p = -p;
    if (m != 0 && a >= 0 && 4 * p <= m * a) return 1'b0;
    return 1'b1;
  endfunction

  // Model: animation derived from counts of frames seen since the last state change.
  int         m_st;       // 0 alive, 1 dying, 2 dead
  int         mv_ticks;
  int         dy_ticks;
  int         mlx, mly, mdir;
  bit         s1_fg, fg_now;
  logic [7:0] m_color;
  bit         m_dd;

  function automatic int mouth_level(int st, int mv, int dyt);
    int chomp [4] = '{4, 2, 0, 2};
    if (st == 0) return chomp[(mv / FRAME_DIV) % 4];
    if (st == 1) return 4 * (dyt / FRAME_DIV + 1);
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; mv_ticks = 0; dy_ticks = 0;
      mlx = 0; mly = 0; mdir = 0;
      s1_fg = 1'b0; m_color = BG; m_dd = 1'b0;
    end else begin
      fg_now  = fg_pixel(int'(xpos), int'(ypos), mlx, mly, mdir, mouth_level(m_st, mv_ticks, dy_ticks));
      m_color = (s1_fg && m_st != 2) ? FG : BG;
      s1_fg   = fg_now;
      m_dd    = 1'b0;
      if (m_st == 0) begin
        if (kill) begin m_st = 1; dy_ticks = 0; end
        else if (frame_tick && moving) mv_ticks++;
      end else if (m_st == 1) begin
        if (frame_tick) begin
          dy_ticks++;
          if (dy_ticks == FRAME_DIV * DEATH_STEPS) begin m_st = 2; m_dd = 1'b1; end
        end
      end else if (revive) begin
        m_st = 0; mv_ticks = 0;
      end
      if (frame_tick) begin mlx = int'(xloc); mly = int'(yloc); mdir = int'(dir); end
    end
  end

  always @(posedge clk) begin
    #1;
    if (death_done === 1'b1) dd_count++;
    if (cmp_en && rst_n === 1'b1) begin
      check("model_color", {24'd0, color}, {24'd0, m_color});
      check("model_alive", {31'd0, alive}, {31'd0, (m_st == 0)});
      check("model_death_done", {31'd0, death_done}, {31'd0, m_dd});
    end
  end

  task automatic tick(output logic dd_seen);
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1; dd_seen = death_done;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] exp, input string name);
    @(negedge clk); xpos = COORD_W'(x); ypos = COORD_W'(y);
    @(posedge clk); @(posedge clk); #1;
    check(name, {24'd0, color}, {24'd0, exp});
  endtask

  task automatic pulse_req(input bit k_in, input bit r_in);
    @(negedge clk); kill = k_in; revive = r_in;
    @(negedge clk); kill = 1'b0; revive = 1'b0;
  endtask

  logic dd;
  int   dd_base;
  int   locs [5] = '{100, 3, 1020, 0, 512};

  initial begin
    check("pin_mouth_right", {31'd0, fg_pixel(104, 100, 100, 100, 0, 4)}, 32'd0);
    check("pin_body_left",   {31'd0, fg_pixel(94, 100, 100, 100, 0, 4)}, 32'd1);
    check("pin_no_wrap",     {31'd0, fg_pixel(1023, 3, 3, 3, 0, 4)}, 32'd0);
    check("pin_half_mouth",  {31'd0, fg_pixel(104, 103, 100, 100, 0, 2)}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_color", {24'd0, color}, {24'd0, BG});
    check("reset_alive", {31'd0, alive}, 32'd1);
    check("reset_death_done", {31'd0, death_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cmp_en = 1'b1;

    xloc = 10'd100; yloc = 10'd100; dir = 2'd0;
    tick(dd);
    pix(104, 100, BG, "mouth_open_right");
    pix(94, 100, FG, "body_left_of_centre");
    pix(100, 108, BG, "outside_box");

    // Chomp: phases 0..3 give m = 4,2,0,2; (104,103) separates 4 from 2, (104,101) catches 0.
    pix(104, 101, BG, "phase0_p1");
    pix(104, 103, BG, "phase0_p3");
    moving = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(dd);
      if (i % 4 == 0) begin
        pix(104, 101, (i == 8) ? FG : BG, "chomp_p1");
        pix(104, 103, FG, "chomp_p3");
      end
    end
    moving = 1'b0;
    for (int i = 0; i < 8; i++) tick(dd);
    pix(104, 101, BG, "frozen_p1");
    pix(104, 103, FG, "frozen_p3");
    moving = 1'b1;
    for (int i = 0; i < 3; i++) tick(dd);
    pix(104, 103, FG, "resume_not_yet");
    tick(dd);
    pix(104, 103, BG, "resume_phase0");
    moving = 1'b0;

    dir = 2'd1; tick(dd);
    pix(100, 95, BG, "dir_up_mouth");
    dir = 2'd2; tick(dd);
    pix(100, 95, FG, "dir_down_body");
    dir = 2'd1;
    pix(100, 95, FG, "dir_change_no_tick");

    xloc = 10'd3; yloc = 10'd3; dir = 2'd0; tick(dd);
    pix(1023, 3, BG, "edge_no_wrap");
    pix(0, 3, FG, "edge_clip_body");

    xloc = 10'd100; yloc = 10'd100; tick(dd);
    dd_base = dd_count;
    pulse_req(1'b1, 1'b0);
    check("kill_alive_low", {31'd0, alive}, 32'd0);
    for (int i = 0; i < FRAME_DIV * DEATH_STEPS; i++) begin
      moving = 1'($urandom_range(0, 1));
      tick(dd);
      check("death_done_timing", {31'd0, dd}, {31'd0, (i == FRAME_DIV * DEATH_STEPS - 1)});
      check("dying_alive_low", {31'd0, alive}, 32'd0);
    end
    @(negedge clk);
    check("death_done_once", dd_count - dd_base, 32'd1);
    pix(94, 100, BG, "dead_blank_body");
    pix(100, 100, BG, "dead_blank_centre");
    pulse_req(1'b1, 1'b0);
    check("kill_in_dead_ignored", {31'd0, alive}, 32'd0);
    pix(94, 100, BG, "still_dead");
    pulse_req(1'b0, 1'b1);
    check("revive_alive", {31'd0, alive}, 32'd1);
    pix(94, 100, FG, "revive_body");
    pix(104, 100, BG, "revive_mouth_open");

    pulse_req(1'b1, 1'b1);
    check("kill_revive_alive_takes_kill", {31'd0, alive}, 32'd0);
    tick(dd); tick(dd);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("async_reset_color", {24'd0, color}, {24'd0, BG});
    check("async_reset_alive", {31'd0, alive}, 32'd1);
    check("async_reset_no_dd", {31'd0, death_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 7) == 0);
      kill       = ($urandom_range(0, 59) == 0);
      revive     = ($urandom_range(0, 15) == 0);
      moving     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        xloc = COORD_W'(locs[$urandom_range(0, 4)]);
        yloc = COORD_W'(locs[$urandom_range(0, 4)]);
      end
      if ($urandom_range(0, 7) != 0) begin
        xpos = COORD_W'(int'(xloc) + int'($urandom_range(0, 2 * R + 2)) - (R + 1));
        ypos = COORD_W'(int'(yloc) + int'($urandom_range(0, 2 * R + 2)) - (R + 1));
      end else begin
        xpos = COORD_W'($urandom);
        ypos = COORD_W'($urandom);
      end
    end
    @(negedge clk);
    frame_tick = 1'b0; kill = 1'b0; revive = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
